// File: rtl/trace_pkg.sv
// Shared types and constants for the pipeline trace monitor.
package trace_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } state_t;

  localparam int unsigned RD_W = 5;
  localparam logic [RD_W-1:0] X0_IDX = 5'd0;

  // A trace entry is {rd, data}.
  function automatic int unsigned entry_w(input int unsigned xlen);
    return xlen + RD_W;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular trace buffer: overwrite-oldest on full, separate occupancy count, sticky overflow.
module trace_fifo #(
  parameter int unsigned WIDTH = 69,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             overflow_q;
  logic             full, do_pop, adv_rd;

  assign full   = (count_q == CntW'(DEPTH));
  assign do_pop = pop && (count_q != '0);
  // Read pointer also moves when a push displaces the oldest entry.
  assign adv_rd = do_pop || (push && full);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (adv_rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !full && !do_pop)  count_q <= count_q + CntW'(1);
      else if (do_pop && !push)      count_q <= count_q - CntW'(1);
      if (push && full && !do_pop) overflow_q <= 1'b1;
    end
  end

  assign head_valid = (count_q != '0);
  // Gated so the head reads as zero while empty, including straight after reset.
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule

// File: rtl/pipe_trace_monitor.sv
// Execution monitor: run/halt FSM, PC-stuck halt detector, cycle/retire counters and
// a trace buffer of architectural register writes.
module pipe_trace_monitor
  import trace_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HALT_CYCLES = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   en,
  input  logic [XLEN-1:0]        pc,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   pop,
  output logic                   trace_valid,
  output logic [4:0]             trace_rd,
  output logic [XLEN-1:0]        trace_data,
  output logic [$clog2(DEPTH):0] trace_count,
  output logic                   overflow,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       retire_cnt,
  output logic                   halted
);

  localparam int unsigned EntryW  = entry_w(XLEN);
  localparam int unsigned StableW = $clog2(HALT_CYCLES + 1);
  localparam logic [StableW-1:0] StableMax = StableW'(HALT_CYCLES);

  state_t               state_q, state_d;
  logic [XLEN-1:0]      pc_prev_q;
  logic [StableW-1:0]   stable_q, stable_d;
  logic [CNT_W-1:0]     cycle_q, retire_q;
  logic                 in_run, pc_same, push;
  logic [EntryW-1:0]    head_entry;

  assign in_run  = (state_q == StRun);
  assign pc_same = (pc == pc_prev_q);

  always_comb begin
    state_d  = state_q;
    stable_d = '0;
    if (in_run && pc_same) begin
      stable_d = (stable_q == StableMax) ? stable_q : stable_q + StableW'(1);
    end
    unique case (state_q)
      StIdle:   if (en) state_d = StRun;
      StRun: begin
        if (!en)                         state_d = StIdle;
        else if (stable_d == StableMax)  state_d = StHalted;
      end
      StHalted: begin
        if (!en)          state_d = StIdle;
        else if (!pc_same) state_d = StRun;
      end
      default:  state_d = StIdle;
    endcase
    if (clear) begin
      state_d  = StIdle;
      stable_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_prev_q <= '0;
      stable_q  <= '0;
      cycle_q   <= '0;
      retire_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_prev_q <= pc;
      stable_q  <= stable_d;
      if (clear) begin
        cycle_q  <= '0;
        retire_q <= '0;
      end else if (in_run) begin
        if (cycle_q != '1)                retire_q <= retire_q;
        if (cycle_q != '1)                cycle_q  <= cycle_q + CNT_W'(1);
        if (wb_valid && (retire_q != '1)) retire_q <= retire_q + CNT_W'(1);
      end
    end
  end

  assign push = in_run && !clear && wb_valid && (wb_rd != X0_IDX);

  trace_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .push       (push),
    .push_data  ({wb_rd, wb_data}),
    .pop        (pop),
    .head_valid (trace_valid),
    .head_data  (head_entry),
    .count      (trace_count),
    .overflow   (overflow)
  );

  assign trace_rd   = head_entry[XLEN +: 5];
  assign trace_data = head_entry[XLEN-1:0];
  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
  assign halted     = (state_q == StHalted);

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Randomised and directed bench for pipe_trace_monitor against a queue-based reference model.
module tb_pipe_trace_monitor;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned HALT  = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   reset, clear, en, wb_valid, pop;
  logic [XLEN-1:0]        pc, wb_data;
  logic [4:0]             wb_rd;
  logic                   trace_valid, overflow, halted;
  logic [4:0]             trace_rd;
  logic [XLEN-1:0]        trace_data;
  logic [$clog2(DEPTH):0] trace_count;
  logic [CNT_W-1:0]       cycle_cnt, retire_cnt;

  pipe_trace_monitor #(
    .XLEN        (XLEN),
    .DEPTH       (DEPTH),
    .HALT_CYCLES (HALT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .en          (en),
    .pc          (pc),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .pop         (pop),
    .trace_valid (trace_valid),
    .trace_rd    (trace_rd),
    .trace_data  (trace_data),
    .trace_count (trace_count),
    .overflow    (overflow),
    .cycle_cnt   (cycle_cnt),
    .retire_cnt  (retire_cnt),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=run 2=halted, trace kept as a plain queue.
  typedef struct { logic [4:0] rd; logic [XLEN-1:0] data; } entry_t;
  entry_t          m_q[$];
  int              m_mode, m_stable;
  int unsigned     m_cyc, m_ret;
  bit              m_ovf;
  logic [XLEN-1:0] m_prev;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_mode = 0; m_stable = 0; m_cyc = 0; m_ret = 0; m_ovf = 0; m_prev = '0;
    end else begin
      if (clear) begin
        m_q.delete();
        m_mode = 0; m_stable = 0; m_cyc = 0; m_ret = 0; m_ovf = 0;
      end else begin
        bit run;
        run = (m_mode == 1);
        if (run) begin
          if (m_cyc < CMAX) m_cyc++;
          if (wb_valid && m_ret < CMAX) m_ret++;
        end
        if (pop && m_q.size() > 0) void'(m_q.pop_front());
        if (run && wb_valid && wb_rd != 0) begin
          entry_t e;
          if (m_q.size() == DEPTH) begin
            void'(m_q.pop_front());
            m_ovf = 1;
          end
          e.rd = wb_rd; e.data = wb_data;
          m_q.push_back(e);
        end
        if (run) m_stable = (pc == m_prev) ? ((m_stable < HALT) ? m_stable + 1 : HALT) : 0;
        else     m_stable = 0;
        case (m_mode)
          0: m_mode = en ? 1 : 0;
          1: m_mode = !en ? 0 : (m_stable == HALT) ? 2 : 1;
          default: m_mode = !en ? 0 : (pc != m_prev) ? 1 : 2;
        endcase
      end
      m_prev = pc;
    end
  end

  always @(negedge clk) begin
    chk("trace_valid", trace_valid, m_q.size() != 0);
    chk("trace_count", trace_count, m_q.size());
    if (m_q.size() != 0) begin
      chk("trace_rd", trace_rd, m_q[0].rd);
      chk("trace_data", trace_data, m_q[0].data);
    end
    chk("overflow", overflow, m_ovf);
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("retire_cnt", retire_cnt, m_ret);
    chk("halted", halted, m_mode == 2);
  end

  bit pc_walk = 1'b0;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (pc_walk) pc = pc + 4;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [XLEN-1:0] d);
    wb_valid = 1'b1; wb_rd = rd; wb_data = d;
    cyc();
    wb_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, trace_valid, 0);
    chk({tag, "_count"}, trace_count, 0);
    chk({tag, "_rd"}, trace_rd, 0);
    chk({tag, "_data"}, trace_data, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_cycle"}, cycle_cnt, 0);
    chk({tag, "_retire"}, retire_cnt, 0);
    chk({tag, "_halted"}, halted, 0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; en = 1'b0; wb_valid = 1'b0; pop = 1'b0;
    pc = '0; wb_rd = '0; wb_data = '0;
    repeat (2) cyc();
    chk_zero("reset");

    // Three writebacks, x0 retired but not traced.
    reset = 1'b0; en = 1'b1; pc_walk = 1'b1;
    cyc();
    wb(5'd5, 64'hA);
    wb(5'd6, 64'hB);
    wb(5'd0, 64'hC);
    chk("t1_count", trace_count, 2);
    chk("t1_rd", trace_rd, 5);
    chk("t1_data", trace_data, 64'hA);
    chk("t1_retire", retire_cnt, 3);
    chk("t1_cycle", cycle_cnt, 3);

    // Clear in RUN, then six pushes into a four-deep buffer.
    clear = 1'b1; cyc(); clear = 1'b0;
    chk_zero("clear");
    cyc();
    for (int i = 1; i <= 6; i++) wb(5'(i), 64'(i));
    chk("t2_count", trace_count, 4);
    chk("t2_ovf", overflow, 1);
    for (int i = 3; i <= 6; i++) begin
      chk("t2_pop_rd", trace_rd, i);
      chk("t2_pop_data", trace_data, i);
      pop = 1'b1; cyc(); pop = 1'b0;
    end
    chk("t2_empty", trace_valid, 0);

    // Full buffer with simultaneous push and pop.
    clear = 1'b1; cyc(); clear = 1'b0; cyc();
    for (int i = 1; i <= 4; i++) wb(5'(i), 64'(i * 16));
    pop = 1'b1; wb(5'd9, 64'h99); pop = 1'b0;
    chk("t3_head", trace_rd, 2);
    chk("t3_count", trace_count, 4);
    chk("t3_ovf", overflow, 0);

    // Halt detection on a stuck PC.
    pc_walk = 1'b0; pc = 64'h100;
    clear = 1'b1; cyc(); clear = 1'b0;
    cyc();
    repeat (HALT - 1) cyc();
    chk("t4_not_yet", halted, 0);
    cyc();
    chk("t4_halted", halted, 1);
    wb(5'd7, 64'h77);
    chk("t4_no_capture", trace_count, 0);
    chk("t4_retire", retire_cnt, 0);
    chk("t4_cycle", cycle_cnt, HALT);
    pc = 64'h104; cyc();
    chk("t4_resume", halted, 0);

    // Asynchronous reset mid-burst, then clear while running.
    pc_walk = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'h33;
    cyc(); cyc();
    #2 reset = 1'b1;
    #1 chk_zero("async");
    wb_valid = 1'b0;
    @(negedge clk) reset = 1'b0;
    cyc(); cyc();
    wb(5'd4, 64'h44);
    clear = 1'b1; cyc(); clear = 1'b0;
    chk_zero("clear_run");
    cyc(); cyc();
    chk("t5_rerun", cycle_cnt, 1);

    // Counter saturation with x0-only writebacks.
    wb_valid = 1'b1; wb_rd = 5'd0;
    repeat (300) cyc();
    wb_valid = 1'b0;
    chk("t6_cyc_sat", cycle_cnt, CMAX);
    chk("t6_ret_sat", retire_cnt, CMAX);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      en       = ($urandom_range(0, 99) >= 3);
      clear    = ($urandom_range(0, 99) < 2);
      wb_valid = $urandom_range(0, 1);
      wb_rd    = 5'($urandom_range(0, 31));
      wb_data  = {$urandom, $urandom};
      pop      = ($urandom_range(0, 9) < 4);
      pc_walk  = 1'b0;
      if ($urandom_range(0, 9) == 0) pc = {32'h0, $urandom};
      if ($urandom_range(0, 199) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
      cyc();
    end
    clear = 1'b0; pop = 1'b0; wb_valid = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
